bip_control: RTL and testbench
==============================

BIP_CONTROL -- requirements
Module: bip_control

Interface
REQ-001 SHALL have parameter len_data, default 16, meaning instruction/data width.
REQ-002 SHALL have parameter len_addr, default 11, meaning operand, PC and data-address width.
REQ-003 SHALL have parameter len_opcode, default 5, meaning opcode field width (instr[15:11]).
REQ-004 SHALL have port clk  input  1  single system clock; all state changes on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port start  input  1  begin program execution from IDLE.
REQ-007 SHALL have port instr  input  len_data  program-memory read data, valid the cycle after pc is presented.
REQ-008 SHALL have port pc  output  len_addr  program-memory address.
REQ-009 SHALL have port operand  output  len_addr  IR[10:0], to data-memory address and sign extender.
REQ-010 SHALL have port sel_a  output  2  MUX A select: 0 = data memory, 1 = ALU, 2 = sign-extended operand.
REQ-011 SHALL have port sel_b  output  1  MUX B select: 0 = data memory, 1 = sign-extended operand.
REQ-012 SHALL have port op  output  1  ALU op: 0 = add, 1 = subtract.
REQ-013 SHALL have port wr_acc, wr_ram, rd_ram  output  1 each  accumulator load, data-memory write, data-memory read strobes.
REQ-014 SHALL have port halted  output  1  high while in HALT.
REQ-015 SHALL have port cycles, retired  output  len_data each  running cycle count and retired-instruction count.

Function
REQ-016 SHALL implement FSM states IDLE, FETCH, DECODE, EXEC, WB, HALT.
REQ-017 IDLE: all strobes low; start=1 -> FETCH next cycle; start ignored in every other state.
REQ-018 FETCH: pc drives current PC; always -> DECODE.
REQ-019 DECODE: IR <= instr; always -> EXEC.
REQ-020 EXEC decode of IR opcode: HLT 00000 -> HALT, no strobes, PC unchanged.
REQ-021 EXEC STO 00001: wr_ram=1 for one cycle -> FETCH.
REQ-022 EXEC LDI 00011: sel_a=2, wr_acc=1 -> FETCH; ADDI 00101 / SUBI 00111: sel_a=1, sel_b=1, op=0/1, wr_acc=1 -> FETCH.
REQ-023 EXEC LD 00010, ADD 00100, SUB 00110: rd_ram=1, no wr_acc -> WB.
REQ-024 WB: LD sel_a=0; ADD/SUB sel_a=1, sel_b=0, op=0/1; wr_acc=1 for one cycle -> FETCH.
REQ-025 Any other opcode SHALL execute as NOP: no strobes, EXEC -> FETCH.
REQ-026 Latency: immediate/STO/NOP 3 cycles, memory-operand 4 cycles, FETCH to next FETCH.
REQ-027 PC SHALL increment by 1 on every EXEC->FETCH transition and WB->FETCH transition; wraps 2^len_addr-1 -> 0.
REQ-028 Each strobe SHALL be asserted exactly one cycle per instruction, never in IDLE, FETCH, DECODE or HALT.
REQ-029 Outputs other than pc SHALL be combinational from state and IR; operand SHALL equal IR[10:0] in all states.
REQ-030 cycles SHALL increment every cycle in FETCH/DECODE/EXEC/WB, wrap modulo 2^len_data, freeze in IDLE and HALT.
REQ-031 retired SHALL increment once per completed instruction (including HLT and NOP), wrap modulo 2^len_data.
REQ-032 HALT SHALL be terminal: halted=1, only reset exits.

Reset
REQ-033 reset SHALL dominate every state, including mid-instruction, and in the same edge SHALL force state=IDLE, PC=0, IR=0, cycles=0, retired=0.
REQ-034 After reset all strobes, sel_a, sel_b, op and halted SHALL read 0.

Structure
REQ-035 Opcode constants, state encodings and sel_a/sel_b encodings SHALL live in a shared package/include used by the datapath.
REQ-036 Opcode decoding SHALL be a combinational sub-module bip_decoder (IR opcode in, sel_a/sel_b/op/strobe class out); PC, IR, counters and FSM stay in bip_control.

Verification
REQ-037 Reset then start pulse, program LDI 5; HLT -> EXEC cycle sel_a=2, wr_acc=1; halted=1 after 6 cycles; retired=2, cycles=6.
REQ-038 Program LD 3; ADD 4; STO 5; HLT -> rd_ram in EXEC and wr_acc in WB for LD/ADD, op=0, wr_ram once with operand=5, pc sequence 0,1,2,3.
REQ-039 SUBI 1 followed by opcode 11111 -> SUBI op=1, sel_b=1; NOP produces no strobes, pc advances to 2.
REQ-040 Assert reset during WB of ADD -> next cycle state IDLE, pc=0, wr_acc=0, counters=0; start restarts at pc=0.
REQ-041 Preload PC path with 2047 NOPs then LDI -> pc wraps 2047 -> 0.
REQ-042 start held high in HALT and during execution -> no effect; HALT persists until reset.

Source files
------------

// File: rtl/bip_control_pkg.sv
// Shared encodings for the BIP controller: opcodes, FSM states, mux selects and the
// instruction classes produced by the decoder.
package bip_control_pkg;

   localparam int unsigned OpcodeWidth = 5;

   localparam logic [OpcodeWidth-1:0] OpHlt  = 5'b00000;
   localparam logic [OpcodeWidth-1:0] OpSto  = 5'b00001;
   localparam logic [OpcodeWidth-1:0] OpLd   = 5'b00010;
   localparam logic [OpcodeWidth-1:0] OpLdi  = 5'b00011;
   localparam logic [OpcodeWidth-1:0] OpAdd  = 5'b00100;
   localparam logic [OpcodeWidth-1:0] OpAddi = 5'b00101;
   localparam logic [OpcodeWidth-1:0] OpSub  = 5'b00110;
   localparam logic [OpcodeWidth-1:0] OpSubi = 5'b00111;

   localparam logic [1:0] SelAMem = 2'd0;
   localparam logic [1:0] SelAAlu = 2'd1;
   localparam logic [1:0] SelAImm = 2'd2;

   localparam logic SelBMem = 1'b0;
   localparam logic SelBImm = 1'b1;

   localparam logic AluAdd = 1'b0;
   localparam logic AluSub = 1'b1;

   typedef enum logic [2:0] {
      StIdle,
      StFetch,
      StDecode,
      StExec,
      StWb,
      StHalt
   } state_e;

   // ClsImm writes the accumulator in EXEC; ClsMem reads RAM in EXEC and writes in WB.
   typedef enum logic [2:0] {
      ClsHalt,
      ClsStore,
      ClsImm,
      ClsMem,
      ClsNop
   } iclass_e;

   function automatic logic is_busy(input state_e s);
      return s inside {StFetch, StDecode, StExec, StWb};
   endfunction

endpackage

// File: rtl/bip_control_if.sv
// Program-memory and datapath-control bundle between the BIP controller and its
// surroundings; the controller takes the master side.
interface bip_control_if #(
   parameter int unsigned len_data = 16,
   parameter int unsigned len_addr = 11
);

   logic                start;
   logic [len_data-1:0] instr;
   logic [len_addr-1:0] pc;
   logic [len_addr-1:0] operand;
   logic [1:0]          sel_a;
   logic                sel_b;
   logic                op;
   logic                wr_acc;
   logic                wr_ram;
   logic                rd_ram;
   logic                halted;
   logic [len_data-1:0] cycles;
   logic [len_data-1:0] retired;

   modport master (
      input  start, instr,
      output pc, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted, cycles, retired
   );

   modport slave (
      output start, instr,
      input  pc, operand, sel_a, sel_b, op, wr_acc, wr_ram, rd_ram, halted, cycles, retired
   );

endinterface

// File: rtl/bip_decoder.sv
// Combinational opcode decoder: instruction class plus the mux/ALU settings used in
// the cycle that loads the accumulator. Unknown opcodes decode as NOP.
module bip_decoder
   import bip_control_pkg::*;
#(
   parameter int unsigned len_opcode = OpcodeWidth
) (
   input  logic [len_opcode-1:0] opcode,
   output iclass_e               iclass,
   output logic [1:0]            sel_a,
   output logic                  sel_b,
   output logic                  op
);

   always_comb begin
      iclass = ClsNop;
      sel_a  = SelAMem;
      sel_b  = SelBMem;
      op     = AluAdd;
      case (opcode)
         len_opcode'(OpHlt): iclass = ClsHalt;
         len_opcode'(OpSto): iclass = ClsStore;
         len_opcode'(OpLdi): begin
            iclass = ClsImm;
            sel_a  = SelAImm;
         end
         len_opcode'(OpAddi): begin
            iclass = ClsImm;
            sel_a  = SelAAlu;
            sel_b  = SelBImm;
         end
         len_opcode'(OpSubi): begin
            iclass = ClsImm;
            sel_a  = SelAAlu;
            sel_b  = SelBImm;
            op     = AluSub;
         end
         len_opcode'(OpLd): begin
            iclass = ClsMem;
            sel_a  = SelAMem;
         end
         len_opcode'(OpAdd): begin
            iclass = ClsMem;
            sel_a  = SelAAlu;
         end
         len_opcode'(OpSub): begin
            iclass = ClsMem;
            sel_a  = SelAAlu;
            op     = AluSub;
         end
         default: iclass = ClsNop;
      endcase
   end

endmodule

// File: rtl/bip_control.sv
// BIP multi-cycle controller: fetch/decode/execute FSM driving the accumulator datapath,
// plus program counter, instruction register and cycle/retired counters.
module bip_control
   import bip_control_pkg::*;
#(
   parameter int unsigned len_data   = 16,
   parameter int unsigned len_addr   = 11,
   parameter int unsigned len_opcode = OpcodeWidth
) (
   input logic           clk,
   input logic           reset,
   bip_control_if.master bus
);

   state_e              state_q, state_d;
   logic [len_addr-1:0] pc_q;
   logic [len_data-1:0] ir_q;
   logic [len_data-1:0] cycles_q;
   logic [len_data-1:0] retired_q;

   iclass_e    iclass;
   logic [1:0] dec_sel_a;
   logic       dec_sel_b;
   logic       dec_op;

   logic       pc_advance;
   logic       ir_load;
   logic       retire;
   logic [1:0] sel_a;
   logic       sel_b;
   logic       op;
   logic       wr_acc;
   logic       wr_ram;
   logic       rd_ram;

   bip_decoder #(
      .len_opcode (len_opcode)
   ) u_decoder (
      .opcode (ir_q[len_data-1 -: len_opcode]),
      .iclass (iclass),
      .sel_a  (dec_sel_a),
      .sel_b  (dec_sel_b),
      .op     (dec_op)
   );

   always_comb begin
      state_d    = state_q;
      pc_advance = 1'b0;
      ir_load    = 1'b0;
      retire     = 1'b0;
      sel_a      = SelAMem;
      sel_b      = SelBMem;
      op         = AluAdd;
      wr_acc     = 1'b0;
      wr_ram     = 1'b0;
      rd_ram     = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.start) state_d = StFetch;
         end
         StFetch:  state_d = StDecode;
         StDecode: begin
            ir_load = 1'b1;
            state_d = StExec;
         end
         StExec: begin
            case (iclass)
               ClsHalt: begin
                  retire  = 1'b1;
                  state_d = StHalt;
               end
               ClsStore: begin
                  wr_ram     = 1'b1;
                  retire     = 1'b1;
                  pc_advance = 1'b1;
                  state_d    = StFetch;
               end
               ClsImm: begin
                  sel_a      = dec_sel_a;
                  sel_b      = dec_sel_b;
                  op         = dec_op;
                  wr_acc     = 1'b1;
                  retire     = 1'b1;
                  pc_advance = 1'b1;
                  state_d    = StFetch;
               end
               // Memory operand: the read data is only usable by the datapath in WB.
               ClsMem: begin
                  rd_ram  = 1'b1;
                  state_d = StWb;
               end
               default: begin
                  retire     = 1'b1;
                  pc_advance = 1'b1;
                  state_d    = StFetch;
               end
            endcase
         end
         StWb: begin
            sel_a      = dec_sel_a;
            sel_b      = SelBMem;
            op         = dec_op;
            wr_acc     = 1'b1;
            retire     = 1'b1;
            pc_advance = 1'b1;
            state_d    = StFetch;
         end
         StHalt:  state_d = StHalt;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         pc_q      <= '0;
         ir_q      <= '0;
         cycles_q  <= '0;
         retired_q <= '0;
      end else begin
         state_q <= state_d;
         if (pc_advance) pc_q <= pc_q + len_addr'(1);
         if (ir_load) ir_q <= bus.instr;
         if (is_busy(state_q)) cycles_q <= cycles_q + len_data'(1);
         if (retire) retired_q <= retired_q + len_data'(1);
      end
   end

   assign bus.pc      = pc_q;
   assign bus.operand = ir_q[len_addr-1:0];
   assign bus.sel_a   = sel_a;
   assign bus.sel_b   = sel_b;
   assign bus.op      = op;
   assign bus.wr_acc  = wr_acc;
   assign bus.wr_ram  = wr_ram;
   assign bus.rd_ram  = rd_ram;
   assign bus.halted  = (state_q == StHalt);
   assign bus.cycles  = cycles_q;
   assign bus.retired = retired_q;

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: an instruction-level model predicts every strobe
// cycle and the final counters; a negedge monitor pops and compares strobe events.
module tb_bip_control;
   import bip_control_pkg::*;

   localparam int unsigned LD       = 16;
   localparam int unsigned LA       = 11;
   localparam int unsigned MemWords = 2048;

   localparam logic [1:0] KWrRam = 2'd0;
   localparam logic [1:0] KRdRam = 2'd1;
   localparam logic [1:0] KWrAcc = 2'd2;

   typedef struct packed {
      logic [1:0]  kind;
      logic [10:0] pc;
      logic [10:0] operand;
      logic [1:0]  sel_a;
      logic        sel_b;
      logic        op;
      logic [15:0] cycles;
   } ev_t;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   bip_control_if #(.len_data(LD), .len_addr(LA)) bus ();

   bip_control #(
      .len_data   (LD),
      .len_addr   (LA),
      .len_opcode (5)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   logic [15:0] pmem [MemWords];
   always @(posedge clk) bus.instr <= pmem[bus.pc];

   ev_t         exp_q [$];
   int          errors = 0;
   int          checks = 0;
   int unsigned exp_pc;
   logic [15:0] exp_cycles;
   logic [15:0] exp_retired;

   function automatic logic [15:0] ins(input logic [4:0] o, input logic [10:0] a);
      return {o, a};
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push(input logic [1:0] k, input int unsigned p, input logic [10:0] a,
                       input logic [1:0] sa, input logic sb, input logic o, input int unsigned c);
      ev_t e;
      e.kind    = k;
      e.pc      = 11'(p);
      e.operand = a;
      e.sel_a   = sa;
      e.sel_b   = sb;
      e.op      = o;
      e.cycles  = 16'(c);
      exp_q.push_back(e);
   endtask

   // Instruction-level model: walks the program, costs 3 or 4 cycles per instruction.
   task automatic model_run(input int patch_step, input int patch_addr, input logic [15:0] patch_val);
      logic [15:0] m [MemWords];
      int unsigned mpc, cyc, ret;
      logic [4:0]  o;
      logic [10:0] a;
      bit          done;
      m = pmem;
      mpc = 0; cyc = 0; ret = 0; done = 0;
      for (int step = 0; step < 5000 && !done; step++) begin
         o = m[mpc][15:11];
         a = m[mpc][10:0];
         ret++;
         if (o == OpHlt) begin
            cyc += 3;
            done = 1;
         end else begin
            case (o)
               OpSto:  push(KWrRam, mpc, a, 2'd0, 1'b0, 1'b0, cyc + 2);
               OpLdi:  push(KWrAcc, mpc, a, 2'd2, 1'b0, 1'b0, cyc + 2);
               OpAddi: push(KWrAcc, mpc, a, 2'd1, 1'b1, 1'b0, cyc + 2);
               OpSubi: push(KWrAcc, mpc, a, 2'd1, 1'b1, 1'b1, cyc + 2);
               OpLd, OpAdd, OpSub: begin
                  push(KRdRam, mpc, a, 2'd0, 1'b0, 1'b0, cyc + 2);
                  push(KWrAcc, mpc, a, (o == OpLd) ? 2'd0 : 2'd1, 1'b0, o == OpSub, cyc + 3);
               end
               default: ;
            endcase
            cyc += (o inside {OpLd, OpAdd, OpSub}) ? 4 : 3;
            mpc = (mpc + 1) % MemWords;
         end
         if (step == patch_step) m[patch_addr] = patch_val;
      end
      exp_pc      = mpc;
      exp_cycles  = 16'(cyc);
      exp_retired = 16'(ret);
   endtask

   always @(negedge clk) begin
      ev_t got, e;
      int  n;
      if (reset === 1'b0) begin
         n = int'(bus.wr_acc) + int'(bus.wr_ram) + int'(bus.rd_ram);
         if (n > 1) begin
            checks++;
            errors++;
            $display("FAIL strobe_overlap: got %0d strobes expected at most 1", n);
         end else if (n == 1) begin
            checks++;
            got.kind    = bus.wr_acc ? KWrAcc : (bus.rd_ram ? KRdRam : KWrRam);
            got.pc      = bus.pc;
            got.operand = bus.operand;
            got.sel_a   = bus.wr_acc ? bus.sel_a : 2'd0;
            got.sel_b   = bus.wr_acc ? bus.sel_b : 1'b0;
            got.op      = bus.wr_acc ? bus.op : 1'b0;
            got.cycles  = bus.cycles;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_strobe: got kind=%0d pc=%0d cyc=%0d expected none",
                        got.kind, got.pc, got.cycles);
            end else begin
               e = exp_q.pop_front();
               if (got !== e) begin
                  errors++;
                  $display({"FAIL strobe_event: got kind=%0d pc=%0d opnd=%0d sel_a=%0d sel_b=%0d",
                            " op=%0d cyc=%0d expected kind=%0d pc=%0d opnd=%0d sel_a=%0d sel_b=%0d",
                            " op=%0d cyc=%0d"},
                           got.kind, got.pc, got.operand, got.sel_a, got.sel_b, got.op,
                           got.cycles, e.kind, e.pc, e.operand, e.sel_a, e.sel_b, e.op,
                           e.cycles);
               end
            end
         end
      end
   end

   task automatic fill_halt();
      for (int i = 0; i < MemWords; i++) pmem[i] = ins(OpHlt, 11'(i));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      repeat (2) @(negedge clk);
      check("rst_pc", 32'(bus.pc), 32'd0);
      check("rst_cycles", 32'(bus.cycles), 32'd0);
      check("rst_retired", 32'(bus.retired), 32'd0);
      check("rst_halted", 32'(bus.halted), 32'd0);
      check("rst_operand", 32'(bus.operand), 32'd0);
      check("rst_ctrl", 32'({bus.sel_a, bus.sel_b, bus.op, bus.wr_acc, bus.wr_ram, bus.rd_ram}),
            32'd0);
   endtask

   task automatic run_program(input bit hold, input int patch_step, input int patch_addr,
                              input logic [15:0] patch_val, input int limit);
      int n;
      bit patched;
      model_run(patch_step, patch_addr, patch_val);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) if (!hold) bus.start = 1'b0;
      n = 0;
      patched = 0;
      while (bus.halted !== 1'b1 && n < limit) begin
         if (patch_step >= 0 && !patched && bus.retired == 16'(patch_step + 1)) begin
            pmem[patch_addr] = patch_val;
            patched = 1;
         end
         @(negedge clk);
         n++;
      end
      check("halt_reached", 32'(bus.halted), 32'd1);
      check("final_retired", 32'(bus.retired), 32'(exp_retired));
      check("final_cycles", 32'(bus.cycles), 32'(exp_cycles));
      check("final_pc", 32'(bus.pc), exp_pc);
      check("queue_drained", 32'(exp_q.size()), 32'd0);
      bus.start = 1'b1;
      repeat (4) @(negedge clk);
      check("halt_sticky", 32'(bus.halted), 32'd1);
      check("halt_retired_frozen", 32'(bus.retired), 32'(exp_retired));
      check("halt_cycles_frozen", 32'(bus.cycles), 32'(exp_cycles));
      bus.start = 1'b0;
   endtask

   initial begin
      int n;
      reset     = 1'b1;
      bus.start = 1'b0;
      fill_halt();

      // LDI 5; HLT
      pmem[0] = ins(OpLdi, 11'd5);
      do_reset();
      run_program(1'b0, -1, 0, 16'h0, 100);
      check("ldi_hlt_cycles", 32'(bus.cycles), 32'd6);
      check("ldi_hlt_retired", 32'(bus.retired), 32'd2);

      // LD 3; ADD 4; STO 5; HLT with start held high throughout
      fill_halt();
      pmem[0] = ins(OpLd, 11'd3);
      pmem[1] = ins(OpAdd, 11'd4);
      pmem[2] = ins(OpSto, 11'd5);
      do_reset();
      run_program(1'b1, -1, 0, 16'h0, 100);

      // SUBI 1; NOP(11111); HLT
      fill_halt();
      pmem[0] = ins(OpSubi, 11'd1);
      pmem[1] = ins(5'b11111, 11'd9);
      do_reset();
      run_program(1'b0, -1, 0, 16'h0, 100);

      // Reset asserted during WB of ADD, then restart from pc 0
      fill_halt();
      pmem[0] = ins(OpLd, 11'd3);
      pmem[1] = ins(OpAdd, 11'd4);
      pmem[2] = ins(OpSto, 11'd5);
      do_reset();
      model_run(-1, 0, 16'h0);
      @(negedge clk) bus.start = 1'b1;
      @(negedge clk) bus.start = 1'b0;
      n = 0;
      while (!(bus.wr_acc === 1'b1 && bus.retired == 16'd1) && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("add_wb_seen", 32'(bus.pc), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      exp_q.delete();
      check("midrst_pc", 32'(bus.pc), 32'd0);
      check("midrst_wr_acc", 32'(bus.wr_acc), 32'd0);
      check("midrst_counters", 32'({bus.cycles, bus.retired}), 32'd0);
      repeat (2) @(negedge clk);
      check("midrst_idle", 32'({bus.pc, bus.cycles}), 32'd0);
      run_program(1'b0, -1, 0, 16'h0, 100);

      // Randomised programs over all 32 opcodes
      for (int t = 0; t < 8; t++) begin
         fill_halt();
         for (int i = 0; i < int'($urandom_range(4, 24)); i++) begin
            logic [4:0] o;
            if ($urandom_range(0, 3) != 0) o = 5'($urandom_range(1, 7));
            else o = 5'($urandom_range(8, 31));
            pmem[i] = ins(o, 11'($urandom));
         end
         do_reset();
         run_program(1'($urandom_range(0, 1)), -1, 0, 16'h0, 300);
      end

      // 2047 NOPs then LDI at 2047; pc wraps to 0 where a HLT is patched in
      for (int i = 0; i < MemWords - 1; i++) pmem[i] = ins(5'b01000, 11'($urandom));
      pmem[MemWords-1] = ins(OpLdi, 11'd7);
      do_reset();
      run_program(1'b0, MemWords - 1, 0, ins(OpHlt, 11'd0), 7000);
      check("wrap_pc", 32'(bus.pc), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
